counter_updn_mod: RTL and testbench



---
 rtl/counter_updn_mod.sv | 120 ++++++++++++
 tb/tb_counter_updn_mod.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/counter_updn_mod.sv
// Modulo-MOD up/down counter digit with cascade carry/borrow, clamped parallel
// load and a manual advance input that auto-repeats while held.
module counter_updn_mod #(
    parameter int W       = 4,
    parameter int MOD     = 10,
    parameter int RPT_DLY = 8,
    parameter int RPT_PER = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enb,
    input  logic         up,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         adv,
    output logic [W-1:0] q,
    output logic         cy
);

    localparam int DW = $clog2(RPT_DLY + 1);
    localparam int PW = $clog2(RPT_PER + 1);

    localparam logic [W-1:0]  Q_MAX    = W'(MOD - 1);
    localparam logic [W:0]    MOD_EXT  = (W + 1)'(MOD);
    localparam logic [DW-1:0] DLY_LAST = DW'(RPT_DLY - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(RPT_PER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RPT  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [PW-1:0] per_q, per_d;
    logic [W-1:0]  q_q, q_d;
    logic          step_s;

    // Advance FSM: first step on press, then one step every RPT_PER cycles after RPT_DLY.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        per_d   = per_q;
        step_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (adv) begin
                    step_s  = 1'b1;
                    state_d = S_HOLD;
                    dly_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!adv) begin
                    state_d = S_IDLE;
                    dly_d   = '0;
                end else if (dly_q == DLY_LAST) begin
                    state_d = S_RPT;
                    per_d   = '0;
                end else begin
                    dly_d = dly_q + DW'(1);
                end
            end
            S_RPT: begin
                if (!adv) begin
                    state_d = S_IDLE;
                    per_d   = '0;
                end else if (per_q == PER_LAST) begin
                    step_s = 1'b1;
                    per_d  = '0;
                end else begin
                    per_d = per_q + PW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                dly_d   = '0;
                per_d   = '0;
            end
        endcase
    end

    // Count next state: load beats step/enable; step and enable together advance once.
    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = ({1'b0, ld_val} >= MOD_EXT) ? Q_MAX : ld_val;
        end else if (step_s || enb) begin
            if (up) begin
                q_d = (q_q == Q_MAX) ? '0 : q_q + W'(1);
            end else begin
                q_d = (q_q == '0) ? Q_MAX : q_q - W'(1);
            end
        end else begin
            q_d = q_q;
        end
    end

    // State, timer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            per_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            per_q   <= per_d;
            q_q     <= q_d;
        end
    end

    assign q  = q_q;
    assign cy = enb & ((up & (q_q == Q_MAX)) | (~up & (q_q == '0)));

endmodule

// File: tb/tb_counter_updn_mod.sv
// Directed bench for counter_updn_mod: cycle-level reference model compared
// every cycle, plus hand-computed literal checkpoints.
module tb_counter_updn_mod;

    localparam int W = 4, MOD = 10, RPT_DLY = 8, RPT_PER = 4;

    logic         clk = 1'b0;
    logic         rst, enb, up, ld, adv;
    logic [W-1:0] ld_val;
    logic [W-1:0] q;
    logic         cy;

    int n_chk = 0;
    int n_fail = 0;

    int mq = 0;
    bit pressed = 1'b0;
    int held = 0;
    bit started = 1'b0;

    counter_updn_mod #(.W(W), .MOD(MOD), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)) dut (
        .clk(clk), .rst(rst), .enb(enb), .up(up), .ld(ld),
        .ld_val(ld_val), .adv(adv), .q(q), .cy(cy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic l,
                         input logic [W-1:0] v, input logic a);
        rst = r; enb = e; up = u; ld = l; ld_val = v; adv = a;
    endtask

    // One clock: compare DUT against model mid-cycle, then advance the model on the edge.
    task automatic tick();
        bit step;
        bit cy_exp;
        @(negedge clk);
        if (started) begin
            cy_exp = enb && ((up && mq == MOD - 1) || (!up && mq == 0));
            chk("q_model", 32'(q), 32'(mq));
            chk("cy_model", 32'(cy), 32'(cy_exp));
        end
        @(posedge clk);
        if (rst) begin
            mq = 0;
            pressed = 1'b0;
            held = 0;
            started = 1'b1;
        end else begin
            step = 1'b0;
            if (adv) begin
                if (!pressed) begin
                    pressed = 1'b1;
                    held = 0;
                    step = 1'b1;
                end else begin
                    held++;
                    if (held >= RPT_DLY + RPT_PER && (held - RPT_DLY) % RPT_PER == 0)
                        step = 1'b1;
                end
            end else begin
                pressed = 1'b0;
            end
            if (ld)
                mq = (int'(ld_val) >= MOD) ? MOD - 1 : int'(ld_val);
            else if (step || enb)
                mq = up ? (mq + 1) % MOD : (mq + MOD - 1) % MOD;
        end
        #1;
    endtask

    task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                       input logic [W-1:0] v, input logic a);
        drive(r, e, u, l, v, a);
        tick();
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        // Reset, then count up through the wrap.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("reset_q", 32'(q), 32'd0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("up_q9", 32'(q), 32'd9);
        chk("up_cy_at9", 32'(cy), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("up_wrap", 32'(q), 32'd0);

        // Down borrow and hold.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        #1;
        chk("dn_cy_at0", 32'(cy), 32'd1);
        tick();
        chk("dn_wrap", 32'(q), 32'd9);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("hold_q5", 32'(q), 32'd5);
        chk("hold_cy0", 32'(cy), 32'd0);

        // Load and clamp, load over enable.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
        chk("ld7", 32'(q), 32'd7);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 1'b0);
        chk("ld_clamp", 32'(q), 32'd9);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
        #1;
        chk("ld_cy_cur", 32'(cy), 32'd1);
        tick();
        chk("ld_over_enb", 32'(q), 32'd3);

        // Hold-to-repeat: 20 cycles gives steps at 0, 12, 16.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("rpt_q3", 32'(q), 32'd3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Step coinciding with enable advances once.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        #1;
        chk("coinc_cy", 32'(cy), 32'd1);
        tick();
        chk("coinc_q", 32'(q), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("toggle_q2", 32'(q), 32'd2);

        // Reset during repeat with adv held, then a fresh press.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("pre_rst_q2", 32'(q), 32'd2);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("rst_rpt_q0", 32'(q), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        chk("rst_repress_q1", 32'(q), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Direction change mid-repeat: down at 0 and 12, up at 16.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, (i < 14) ? 1'b0 : 1'b1, 1'b0, 4'd0, 1'b1);
        chk("dir_change_q0", 32'(q), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Load during repeat drops the coincident step; timers keep running.
        for (int i = 0; i < 17; i++)
            cyc(1'b0, 1'b0, 1'b1, (i == 12) ? 1'b1 : 1'b0, 4'd5, 1'b1);
        chk("ld_in_rpt_q6", 32'(q), 32'd6);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
